// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA field-arithmetic blocks: field/limb
// geometry, the serial add/sub controller states and the secp256k1 prime.
package ecdsa_pkg;

    localparam int unsigned FIELD_W = 256;
    localparam int unsigned LIMB_W  = 16;
    localparam int unsigned N_LIMB  = FIELD_W / LIMB_W;

    // Two passes over the limbs, then a single result-valid cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } addsub_state_t;

    // secp256k1 field prime, used by benches as the default modulus.
    localparam logic [FIELD_W-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/adder_16.sv
// 16-bit ripple adder limb with carry in/out; the only arithmetic element
// of the serial modular adder/subtractor.
module adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] total;

    // Full-width sum; the top bit is the carry out of the limb.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        sum   = total[15:0];
        cout  = total[16];
    end

endmodule

// File: rtl/mod_addsub_serial.sv
// Iterative modular adder/subtractor for field elements. Operands stream
// LSB-limb first through one adder_16: pass 1 forms a+b or a-b, pass 2
// forms the reduced candidate (s-p or s+p) and the correct one is kept.
// Both passes always run so latency does not depend on the data.
module mod_addsub_serial
    import ecdsa_pkg::*;
#(
    parameter int unsigned WIDTH = FIELD_W,
    parameter int unsigned LIMB  = LIMB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int unsigned N     = WIDTH / LIMB;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    addsub_state_t    state;
    addsub_state_t    state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;     // already inverted for subtraction
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] t_nxt;
    logic             op_q;
    logic             carry;
    logic             c1;
    logic [IDX_W-1:0] idx;
    logic             last;
    int unsigned      lsb;

    logic [LIMB-1:0]  lim_a;
    logic [LIMB-1:0]  lim_b;
    logic [LIMB-1:0]  lim_sum;
    logic             lim_cout;
    logic             keep_t;

    assign last = (idx == IDX_W'(N - 1));
    assign lsb  = LIMB * idx;
    assign busy = (state == ST_PASS1) || (state == ST_PASS2);
    assign done = (state == ST_DONE);

    // add: keep s-p when the raw sum overflowed or s >= p;
    // sub: keep s+p only when a-b borrowed.
    assign keep_t = op_q ? ~c1 : (c1 | lim_cout);

    adder_16 u_adder (
        .a    (lim_a),
        .b    (lim_b),
        .cin  (carry),
        .sum  (lim_sum),
        .cout (lim_cout)
    );

    // Limb operand selection: a/b' in pass 1, s and +-p in pass 2.
    always_comb begin
        lim_a = a_q[lsb +: LIMB];
        lim_b = b_q[lsb +: LIMB];
        if (state == ST_PASS2) begin
            lim_a = s_q[lsb +: LIMB];
            lim_b = op_q ? p_q[lsb +: LIMB] : ~p_q[lsb +: LIMB];
        end
    end

    // Candidate result with the current limb merged in.
    always_comb begin
        t_nxt = t_q;
        t_nxt[lsb +: LIMB] = lim_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only sampled in IDLE, passes end on the last limb.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_PASS1;
            ST_PASS1: if (last)  state_nxt = ST_PASS2;
            ST_PASS2: if (last)  state_nxt = ST_DONE;
            ST_DONE:             state_nxt = ST_IDLE;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // Operand latching, limb stepping, carry chain and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            s_q   <= '0;
            t_q   <= '0;
            op_q  <= 1'b0;
            carry <= 1'b0;
            c1    <= 1'b0;
            idx   <= '0;
            r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= op_sub ? ~b : b;
                        p_q   <= p;
                        op_q  <= op_sub;
                        carry <= op_sub;
                        idx   <= '0;
                    end
                end
                ST_PASS1: begin
                    s_q[lsb +: LIMB] <= lim_sum;
                    if (last) begin
                        c1    <= lim_cout;
                        carry <= ~op_q;
                        idx   <= '0;
                    end else begin
                        carry <= lim_cout;
                        idx   <= idx + 1'b1;
                    end
                end
                ST_PASS2: begin
                    t_q   <= t_nxt;
                    carry <= lim_cout;
                    if (last) begin
                        idx <= '0;
                        r   <= keep_t ? t_nxt : s_q;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
